// File: rtl/mem_pkg.sv
// Shared definitions for the load/store sequencer.
//   state_e  : sequencer FSM states
//   SZ_*     : access size codes (byte, half, word, dword)
//   EXC_*    : exception codes returned with every response
//   size_be  : byte-enable pattern of an access, right-aligned (lane 0)
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_ADES = 2'b10;
  localparam logic [1:0] EXC_BUS  = 2'b11;

  function automatic logic [7:0] size_be(input logic [1:0] size);
    case (size)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_ls_align.sv
// ls_align: purely combinational lane logic for the load/store sequencer.
// Ports:
//   chk_lane_i/chk_size_i : byte lane and size of the incoming request
//   misaligned_o          : access is not naturally aligned (or dword on 32-bit)
//   st_data_i             : right-aligned store data of the incoming request
//   st_be_o/st_data_o     : byte enables and store data moved to their lanes
//   ld_lane_i/ld_size_i/ld_sext_i : registered lane, size, sign flag of the load
//   ld_raw_i              : raw bus read data
//   ld_data_o             : selected and extended load result
module ls_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int LW = $clog2(NB)
) (
  input  logic [LW-1:0]     chk_lane_i,
  input  logic [1:0]        chk_size_i,
  output logic              misaligned_o,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [NB-1:0]     st_be_o,
  output logic [DATA_W-1:0] st_data_o,
  input  logic [LW-1:0]     ld_lane_i,
  input  logic [1:0]        ld_size_i,
  input  logic              ld_sext_i,
  input  logic [DATA_W-1:0] ld_raw_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [NB-1:0]     st_be_base;
  logic [NB-1:0]     ld_be_base;
  logic [DATA_W-1:0] st_bmask;
  logic [DATA_W-1:0] ld_bmask;
  logic [DATA_W-1:0] ld_shift;
  logic              ld_sign;

  always_comb begin
    st_be_base = NB'(size_be(chk_size_i));
    ld_be_base = NB'(size_be(ld_size_i));
    for (int i = 0; i < DATA_W; i++) begin
      st_bmask[i] = st_be_base[i/8];
      ld_bmask[i] = ld_be_base[i/8];
    end

    case (chk_size_i)
      SZ_B:    misaligned_o = 1'b0;
      SZ_H:    misaligned_o = chk_lane_i[0];
      SZ_W:    misaligned_o = |chk_lane_i[1:0];
      default: misaligned_o = (DATA_W == 32) ? 1'b1 : (|chk_lane_i);
    endcase

    // Store data may carry junk above the access size; mask before shifting.
    st_be_o   = st_be_base << chk_lane_i;
    st_data_o = (st_data_i & st_bmask) << {chk_lane_i, 3'b000};

    ld_shift = ld_raw_i >> {ld_lane_i, 3'b000};
    case (ld_size_i)
      SZ_B:    ld_sign = ld_shift[7];
      SZ_H:    ld_sign = ld_shift[15];
      SZ_W:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_W-1];
    endcase
    // A full-width access has an all-ones mask, so extension is a no-op.
    ld_data_o = ld_shift & ld_bmask;
    if (ld_sext_i && ld_sign) begin
      ld_data_o = ld_data_o | ~ld_bmask;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store sequencer between the M stage
// and the data bus.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid/req_ready/req_*       : operation offered by the M stage
//   rsp_valid/rsp_ready/rsp_*       : extended load data plus exception code
//   bus_req/bus_gnt/bus_addr/bus_we/bus_be/bus_wdata : bus request phase
//   bus_rvalid/bus_rdata            : bus read data phase
//   busy                            : sequencer not idle; M stage stalls
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising edge; a holder of valid keeps its payload stable until
// that edge. bus_req/bus_gnt and rsp_valid/rsp_ready follow the same rule.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sext,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_exc,
  output logic                bus_req,
  input  logic                bus_gnt,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy
);

  localparam int NB = DATA_W / 8;
  localparam int LW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        exc_q, exc_d;

  logic              al_misaligned;
  logic [NB-1:0]     al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_ldata;
  logic              timed_out;
  logic              in_req;

  // Store lanes are computed from the incoming request and registered, so
  // the bus outputs never see a combinational path from req_*.
  ls_align #(.DATA_W(DATA_W)) u_align (
    .chk_lane_i   (req_addr[LW-1:0]),
    .chk_size_i   (req_size),
    .misaligned_o (al_misaligned),
    .st_data_i    (req_wdata),
    .st_be_o      (al_be),
    .st_data_o    (al_wdata),
    .ld_lane_i    (addr_q[LW-1:0]),
    .ld_size_i    (size_q),
    .ld_sext_i    (sext_q),
    .ld_raw_i     (bus_rdata),
    .ld_data_o    (al_ldata)
  );

  // A late grant can push the count past the last value; >= still ends WAIT.
  assign timed_out = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          size_d  = req_size;
          sext_d  = req_sext;
          be_d    = al_be;
          wdata_d = al_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          if (al_misaligned) begin
            exc_d   = req_we ? EXC_ADES : EXC_ADEL;
            state_d = RESP;
          end else begin
            exc_d   = EXC_NONE;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_gnt) begin
          state_d = we_q ? RESP : WAIT;
        end else if (timed_out) begin
          exc_d   = EXC_BUS;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus_rvalid) begin
          rdata_d = al_ldata;
          state_d = RESP;
        end else if (timed_out) begin
          exc_d   = EXC_BUS;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      exc_q   <= EXC_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign in_req    = (state_q == REQ);
  assign req_ready = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_exc   = rsp_valid ? exc_q : EXC_NONE;
  assign bus_req   = in_req;
  assign bus_we    = in_req & we_q;
  assign bus_be    = in_req ? be_q : '0;
  assign bus_wdata = in_req ? wdata_q : '0;
  assign bus_addr  = in_req ? {addr_q[ADDR_W-1:LW], {LW{1'b0}}} : '0;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store sequencer between the M stage and the data bus. Accepts one memory operation at a time, checks alignment, drives a request/grant/read-valid bus handshake, and returns read data extended to full width together with an exception code. Parametrised in data width and bus timeout; the M stage stalls on `busy`.

## Interface
- `DATA_W`, 32: data width, 32 or 64 only.
- `ADDR_W`, 32: byte-address width.
- `TIMEOUT`, 16: maximum cycles spent in REQ+WAIT before a bus error; must be at least 2.
- `clk` in 1: single clock.
- `reset` in 1: reset, synchronous and active-high.
- `req_valid` in 1: operation offered.
- `req_ready` out 1: equals (state==IDLE) && !reset.
- `req_addr` in ADDR_W: byte address.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- `req_sext` in 1: sign-extend the load result; ignored for stores and full-width loads.
- `req_wdata` in DATA_W: right-aligned store data.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: pipeline accepts the response.
- `rsp_rdata` out DATA_W: extended load data; 0 for stores and exceptions.
- `rsp_exc` out 2: 00 none, 01 AdEL, 10 AdES, 11 bus timeout.
- `bus_req` out 1: bus request.
- `bus_gnt` in 1: bus grant.
- `bus_addr` out ADDR_W: req_addr with its low log2(DATA_W/8) bits cleared.
- `bus_we` out 1: write strobe.
- `bus_be` out DATA_W/8: byte enables.
- `bus_wdata` out DATA_W: store data shifted to its lane.
- `bus_rvalid` in 1: read data valid.
- `bus_rdata` in DATA_W: raw read data.
- `busy` out 1: state != IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: on req_valid && req_ready, register addr, we, size, sext and wdata.
  - Misaligned access, or size 3 with DATA_W=32: go to RESP with exc 01 for a load or 10 for a store. The bus is never touched.
  - Otherwise go to REQ.
- Alignment rule: the address must be a multiple of the access size in bytes.
- REQ: bus_req=1 and the bus_addr/we/be/wdata outputs are held stable until bus_gnt.
  - On gnt with we=1, go to RESP with exc 00. The write completes at grant.
  - On gnt with we=0, go to WAIT.
- WAIT: bus_req=0. On bus_rvalid, latch the extended data and go to RESP.
  - bus_rvalid is honoured only in WAIT; elsewhere it is ignored.
  - Simultaneous rvalid and timeout: rvalid wins.
- Timeout: a counter clears on entry to REQ and increments each cycle in REQ or WAIT. At count TIMEOUT-1 without gnt (REQ) or rvalid (WAIT), go to RESP with exc 11 and rdata 0.
- RESP: rsp_valid=1 with data and exc held stable until rsp_ready, then go to IDLE.
- Load extension: lane = addr[log2(DATA_W/8)-1:0]. Select the byte, half or word at that lane, then zero- or sign-extend to DATA_W. A full-width load returns bus_rdata unchanged.
- Byte enables: contiguous ones of the access size starting at the lane. For example, DATA_W=32, sh at offset 2 gives be=4'b1100 and wdata={wdata[15:0],16'h0}.

## Timing
- Reset: state IDLE; counter 0; `rsp_valid`, `rsp_rdata`, `rsp_exc`, `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata` and `busy` all 0; `req_ready` 0 while reset is high.
- Reset mid-transaction aborts immediately to IDLE. Any outstanding bus read is dropped.
- Read latency with gnt in the first REQ cycle and rvalid k cycles later:
  - accept at cycle 0, REQ at 1, WAIT from 2;
  - rsp_valid at cycle 2+k, where k ≥ 1.
- Write with immediate grant: rsp_valid at cycle 2.
- Misaligned access: rsp_valid at cycle 1.
- No new request is accepted during the rsp_ready handshake cycle. The earliest next accept is one cycle after the response is consumed.
- All outputs are registered or decoded from registered state only. There is no combinational path from `req_*` to `bus_*`.

## Structure
- Package `mem_pkg`:
  - state enum;
  - size codes SZ_B/SZ_H/SZ_W/SZ_D;
  - exception codes EXC_NONE/EXC_ADEL/EXC_ADES/EXC_BUS.
- Sub-module `ls_align`: combinational, parametrised by DATA_W. Provides alignment check, be/wdata lane shifting, and load select/extend. The FSM top instantiates it once.

## Test plan
- DATA_W=32: lb at 0x1003, bus_rdata=0x80FF_0000, gnt immediate, rvalid after 1 cycle -> rsp_rdata=0xFFFF_FF80, exc 00, rsp_valid at cycle 3.
- DATA_W=32: lhu at 0x2002, rdata=0xBEEF_1234 -> 0x0000_BEEF. The same access with req_sext=1 -> 0xFFFF_BEEF.
- sh 0x0000_A5A5 at 0x10, gnt after 3 cycles -> bus_be=4'b0011, wdata=0x0000_A5A5, bus_req high for 4 cycles, rsp exc 00.
- lw at 0x1002 -> exc 01, bus_req never asserted, rsp_valid at cycle 1. sh at 0x1001 -> exc 10.
- TIMEOUT=4, no grant -> exc 11, bus_req drops. A stray rvalid afterwards is ignored, and the next read returns correct data.
- DATA_W=64: ld at 0x8 -> full rdata returned. lw with sext at offset 4, upper word 0x8000_0001 -> 0xFFFF_FFFF_8000_0001. reset asserted in WAIT -> IDLE next cycle with all outputs 0.
